// File: rtl/simon_pkg.sv
// Shared constants, state encoding and round function for the
// iterative Simon32/64 datapath.
package simon_pkg;

    localparam int SIMON_ROUNDS = 32;
    localparam int SIMON_WARMUP = 28;
    localparam int SIMON_W      = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WARM = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [SIMON_W-1:0] simon_f(
        input logic [SIMON_W-1:0] v
    );
        logic [SIMON_W-1:0] r1;
        logic [SIMON_W-1:0] r2;
        logic [SIMON_W-1:0] r8;
        r1 = {v[14:0], v[15]};
        r2 = {v[13:0], v[15:14]};
        r8 = {v[7:0], v[15:8]};
        return (r1 & r8) ^ r2;
    endfunction

endpackage

// File: rtl/simon_round_core_round.sv
// One Simon32/64 round, either direction, purely combinational.
// dir_i=0 encrypts, dir_i=1 applies the inverse round.
module simon_round
    import simon_pkg::*;
(
    input  logic [SIMON_W-1:0] x_i,
    input  logic [SIMON_W-1:0] y_i,
    input  logic [SIMON_W-1:0] k_i,
    input  logic               dir_i,
    output logic [SIMON_W-1:0] x_o,
    output logic [SIMON_W-1:0] y_o
);

    always_comb begin
        x_o = y_i ^ simon_f(x_i) ^ k_i;
        y_o = x_i;
        if (dir_i) begin
            x_o = y_i;
            y_o = x_i ^ simon_f(y_i) ^ k_i;
        end
    end

endmodule

// File: rtl/simon_round_core.sv
// Iterative Simon32/64 encrypt/decrypt core, one round per clock.
// Drives the external key schedule and consumes its subkeys.
module simon_round_core
    import simon_pkg::*;
#(
    parameter int ROUNDS = SIMON_ROUNDS,
    parameter int WARMUP = SIMON_WARMUP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [31:0] block_in,
    output logic [31:0] block_out,
    output logic        busy,
    output logic        done,
    output logic        ks_load,
    output logic        ks_dir,
    output logic [5:0]  ks_round,
    input  logic [15:0] ks_subkey
);

    logic [2:0]  state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        mode_q, mode_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] rx;
    logic [15:0] ry;

    simon_round u_round (
        .x_i   (x_q),
        .y_i   (y_q),
        .k_i   (ks_subkey),
        .dir_i (mode_q),
        .x_o   (rx),
        .y_o   (ry)
    );

    // The key schedule advances on every non-load cycle, so only
    // WARM and RUN may release it from load.
    assign ks_load   = !(state_q == ST_WARM || state_q == ST_RUN);
    assign ks_dir    = (state_q == ST_RUN) && mode_q;
    assign ks_round  = cnt_q;
    assign block_out = out_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = block_in[31:16];
                    y_d     = block_in[15:0];
                    mode_d  = decrypt;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = mode_q ? ST_WARM : ST_RUN;
            end
            ST_WARM: begin
                if (cnt_q == 6'(WARMUP - 1)) begin
                    cnt_d   = 6'(ROUNDS - 1);
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_RUN: begin
                x_d = rx;
                y_d = ry;
                if (mode_q) begin
                    if (cnt_q == 6'd0) state_d = ST_DONE;
                    else cnt_d = cnt_q - 6'd1;
                end else begin
                    if (cnt_q == 6'(ROUNDS - 1)) state_d = ST_DONE;
                    else cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                out_d   = {x_q, y_q};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_simon_round_core.sv
// Scoreboard bench for simon_round_core with a behavioural key
// schedule and Simon32/64 reference model.
module tb_simon_round_core;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [31:0] block_in = '0;
    logic [31:0] block_out;
    logic        busy;
    logic        done;
    logic        ks_load;
    logic        ks_dir;
    logic [5:0]  ks_round;
    logic [15:0] ks_subkey;

    simon_round_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .decrypt   (decrypt),
        .block_in  (block_in),
        .block_out (block_out),
        .busy      (busy),
        .done      (done),
        .ks_load   (ks_load),
        .ks_dir    (ks_dir),
        .ks_round  (ks_round),
        .ks_subkey (ks_subkey)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] blk;
        int          t0;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] seq_q[$];

    // Full expanded key; the schedule model is a sliding 4-word
    // window whose base index moves one step per non-load cycle.
    logic [15:0] kexp[32];
    int          pos = 0;
    int          idx;

    always @(posedge clk) begin
        if (ks_load) pos <= 0;
        else if (ks_dir) pos <= pos - 1;
        else pos <= pos + 1;
    end

    always_comb begin
        idx = ks_dir ? pos + 3 : pos;
        ks_subkey = 16'hDEAD;
        if (idx >= 0 && idx < 32) ks_subkey = kexp[idx];
    end

    function automatic logic [15:0] rol(input logic [15:0] v,
                                        input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ref_f(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    task automatic expand(input logic [63:0] key);
        logic [63:0] z;
        logic [15:0] t;
        z = 64'h19C3_522F_B386_A45F;
        kexp[0] = key[15:0];
        kexp[1] = key[31:16];
        kexp[2] = key[47:32];
        kexp[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t = rol(kexp[i-1], 13) ^ kexp[i-3];
            t = t ^ rol(t, 15);
            kexp[i] = ~kexp[i-4] ^ t ^ {15'd0, z[i-4]} ^ 16'h3;
        end
    endtask

    function automatic logic [31:0] ref_enc(input logic [31:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = b[31:16];
        y = b[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ref_f(x) ^ kexp[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check(input string nm, input bit ok,
                         input logic [63:0] act,
                         input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   ei;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!ks_load) begin
                    seq_q.push_back({ks_dir, ks_round});
                    ei = ks_dir ? pos + 3 : pos;
                    check("ks_round", ks_round == 6'(ei),
                          64'(ks_round), 64'(ei));
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 1'b0, 64'(block_out), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("block_out", block_out === e.blk,
                              64'(block_out), 64'(e.blk));
                        check("latency", (cyc - e.t0) == e.lat,
                              64'(cyc - e.t0), 64'(e.lat));
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [63:0] key,
                         input logic [31:0] blk,
                         input logic dec,
                         input logic [31:0] want);
        exp_t e;
        expand(key);
        block_in = blk;
        decrypt  = dec;
        start    = 1'b1;
        e.blk = want;
        e.t0  = cyc;
        e.lat = dec ? 63 : 35;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            check("timeout", 1'b0, 64'(exp_q.size()), 0);
            exp_q.delete();
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy === 1'b0, 64'(busy), 0);
        check({tag, "_done"}, done === 1'b0, 64'(done), 0);
        check({tag, "_bout"}, block_out === 32'h0,
              64'(block_out), 0);
        check({tag, "_load"}, ks_load === 1'b1, 64'(ks_load), 1);
        check({tag, "_dir"}, ks_dir === 1'b0, 64'(ks_dir), 0);
        check({tag, "_round"}, ks_round === 6'd0, 64'(ks_round), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ok;
        int          k;
        logic [63:0] key;
        logic [31:0] blk;
        logic [31:0] ct;
        logic [6:0]  want_seq[$];

        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(KAT_KEY, KAT_PT, 1'b0, KAT_CT);
        wait_idle(200);

        seq_q.delete();
        issue(KAT_KEY, KAT_CT, 1'b1, KAT_PT);
        wait_idle(200);
        for (int i = 0; i < 28; i++) want_seq.push_back({1'b0, 6'(i)});
        for (int i = 31; i >= 0; i--) want_seq.push_back({1'b1, 6'(i)});
        ok = (seq_q.size() == want_seq.size());
        if (ok)
            for (int i = 0; i < want_seq.size(); i++)
                if (seq_q[i] !== want_seq[i]) ok = 1'b0;
        check("ks_seq", ok, 64'(seq_q.size()), 64'(want_seq.size()));

        // Extra start pulses at cycles 5 and 34 must be ignored.
        issue(KAT_KEY, KAT_PT, 1'b0, KAT_CT);
        ok = 1'b1;
        for (k = 2; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (busy !== (k <= 34)) ok = 1'b0;
            if (k == 5 || k == 34) begin
                start    = 1'b1;
                block_in = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_hold", ok, 64'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        wait_idle(10);
        check("bout_kept", block_out === KAT_CT,
              64'(block_out), 64'(KAT_CT));

        // Reset during RUN round 10.
        issue(KAT_KEY, KAT_PT, 1'b0, KAT_CT);
        repeat (11) @(posedge clk);
        #1;
        check("run_round10", ks_round === 6'd10 && !ks_load,
              64'(ks_round), 10);
        exp_q.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_bout", block_out === 32'h0, 64'(block_out), 0);
        issue(KAT_KEY, KAT_PT, 1'b0, KAT_CT);
        wait_idle(200);

        // Idle gap: schedule must stay in load.
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ks_load !== 1'b1) ok = 1'b0;
        end
        check("idle_load", ok, 64'(ks_load), 1);
        issue(KAT_KEY, KAT_PT, 1'b0, KAT_CT);
        wait_idle(200);

        for (int i = 0; i < 200; i++) begin
            key = {$urandom, $urandom};
            blk = $urandom;
            expand(key);
            ct = ref_enc(blk);
            issue(key, blk, 1'b0, ct);
            wait_idle(200);
            issue(key, ct, 1'b1, blk);
            wait_idle(200);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
